// File: rtl/proc_mem_responder.sv
// proc_mem_responder
//   Word-addressed memory model serving a processor's instruction and data
//   ports, with a streaming program loader, access counters and sticky
//   error flags.
//
//   Ports
//     clk, rst                 clock, asynchronous active-low reset
//     imemreq_val/addr         fetch request (byte address)
//     imemresp_data            fetch data, combinational in SERVE
//     dmemreq_val/type/addr    data request (type 0 = read, 1 = write)
//     dmemreq_wdata            store data
//     dmemresp_rdata           load data, combinational in SERVE
//     load_start               pulse that (re)starts a program load
//     load_val/rdy/data/last   load word stream, handshake on val & rdy
//     busy                     high while loading; processor stalls on it
//     load_done                one-cycle pulse after a load finishes
//     imem_cnt, dmem_rd_cnt,
//     dmem_wr_cnt              wrapping access counters
//     err_misalign/range/
//     overflow                 sticky error flags
//     err_clr                  synchronous clear of the error flags
module proc_mem_responder #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  input  logic        load_start,
  input  logic        load_val,
  output logic        load_rdy,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        busy,
  output logic        load_done,
  output logic [31:0] imem_cnt,
  output logic [31:0] dmem_rd_cnt,
  output logic [31:0] dmem_wr_cnt,
  output logic        err_misalign,
  output logic        err_range,
  output logic        err_overflow,
  input  logic        err_clr
);

  localparam int AW = $clog2(WORDS);
  localparam logic [AW-1:0] PTR_MAX = AW'(WORDS - 1);

  typedef enum logic {
    SERVE = 1'b0,
    LOAD  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ptr;
  logic [31:0]   mem [WORDS];

  logic          in_serve;
  logic          i_oor;
  logic          d_oor;
  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic          load_acc;
  logic          load_wr;
  logic          load_end;
  logic          ovf_evt;
  logic          d_rd;
  logic          d_wr;
  logic          d_wr_ok;
  logic          range_evt;
  logic          mis_evt;
  logic          flag_clr;

  assign in_serve = (state == SERVE);

  // Any address bit above the memory window means out of range.
  assign i_oor = |imemreq_addr[31:AW+2];
  assign d_oor = |dmemreq_addr[31:AW+2];
  assign i_idx = imemreq_addr[AW+1:2];
  assign d_idx = dmemreq_addr[AW+1:2];

  // A load_start in LOAD restarts the stream; the word offered in that
  // same cycle is discarded so the new load begins cleanly at word 0.
  assign load_acc = (state == LOAD) && load_val;
  assign load_wr  = load_acc && !load_start;
  assign ovf_evt  = load_wr && !load_last && (ptr == PTR_MAX);
  assign load_end = load_wr && (load_last || (ptr == PTR_MAX));

  assign d_rd    = in_serve && dmemreq_val && !dmemreq_type;
  assign d_wr    = in_serve && dmemreq_val && dmemreq_type;
  assign d_wr_ok = d_wr && !d_oor;

  assign range_evt = in_serve && ((imemreq_val && i_oor) ||
                                  (dmemreq_val && d_oor));
  assign mis_evt   = in_serve && ((imemreq_val && (|imemreq_addr[1:0])) ||
                                  (dmemreq_val && (|dmemreq_addr[1:0])));
  assign flag_clr  = err_clr || load_start;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SERVE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      SERVE: if (load_start) state_nxt = LOAD;
      LOAD: begin
        if (load_start)    state_nxt = LOAD;
        else if (load_end) state_nxt = SERVE;
      end
      default: state_nxt = SERVE;
    endcase
  end

  // Output logic; reads return zero while loading or when out of range.
  always_comb begin
    load_rdy       = (state == LOAD);
    imemresp_data  = '0;
    dmemresp_rdata = '0;
    if (in_serve && !i_oor) imemresp_data  = mem[i_idx];
    if (in_serve && !d_oor) dmemresp_rdata = mem[d_idx];
  end

  // Loader control, counters and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= 1'b0;
      load_done    <= 1'b0;
      ptr          <= '0;
      imem_cnt     <= '0;
      dmem_rd_cnt  <= '0;
      dmem_wr_cnt  <= '0;
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      busy      <= (state_nxt == LOAD);
      load_done <= load_end;

      // ptr saturates at the last word so an overflow never wraps onto word 0.
      if (load_start)                     ptr <= '0;
      else if (load_wr && ptr != PTR_MAX) ptr <= ptr + 1'b1;

      if (in_serve && imemreq_val) imem_cnt    <= imem_cnt + 32'd1;
      if (d_rd)                    dmem_rd_cnt <= dmem_rd_cnt + 32'd1;
      if (d_wr)                    dmem_wr_cnt <= dmem_wr_cnt + 32'd1;

      // A new event in the same cycle as a clear leaves the flag set.
      err_misalign <= mis_evt   || (err_misalign && !flag_clr);
      err_range    <= range_evt || (err_range    && !flag_clr);
      err_overflow <= ovf_evt   || (err_overflow && !flag_clr);
    end
  end

  // Storage array: deliberately not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      mem[ptr] <= load_data;
    end else if (d_wr_ok) begin
      mem[d_idx] <= dmemreq_wdata;
    end
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
module tb_proc_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        load_start;
  logic        load_val;
  logic        load_rdy;
  logic [31:0] load_data;
  logic        load_last;
  logic        busy;
  logic        load_done;
  logic [31:0] imem_cnt;
  logic [31:0] dmem_rd_cnt;
  logic [31:0] dmem_wr_cnt;
  logic        err_misalign;
  logic        err_range;
  logic        err_overflow;
  logic        err_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_mem_responder #(.WORDS(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .imemreq_val    (imemreq_val),
    .imemreq_addr   (imemreq_addr),
    .imemresp_data  (imemresp_data),
    .dmemreq_val    (dmemreq_val),
    .dmemreq_type   (dmemreq_type),
    .dmemreq_addr   (dmemreq_addr),
    .dmemreq_wdata  (dmemreq_wdata),
    .dmemresp_rdata (dmemresp_rdata),
    .load_start     (load_start),
    .load_val       (load_val),
    .load_rdy       (load_rdy),
    .load_data      (load_data),
    .load_last      (load_last),
    .busy           (busy),
    .load_done      (load_done),
    .imem_cnt       (imem_cnt),
    .dmem_rd_cnt    (dmem_rd_cnt),
    .dmem_wr_cnt    (dmem_wr_cnt),
    .err_misalign   (err_misalign),
    .err_range      (err_range),
    .err_overflow   (err_overflow),
    .err_clr        (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; registered results of the
  // preceding rising edge are sampled at that same falling edge.
  initial begin
    rst = 1'b0;
    imemreq_val = 0; imemreq_addr = 0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
    load_start = 0; load_val = 0; load_data = 0; load_last = 0; err_clr = 0;

    #12;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst load_rdy", {31'd0, load_rdy}, 32'd0);
    chk("rst load_done", {31'd0, load_done}, 32'd0);
    chk("rst imem_cnt", imem_cnt, 32'd0);
    chk("rst dmem_rd_cnt", dmem_rd_cnt, 32'd0);
    chk("rst dmem_wr_cnt", dmem_wr_cnt, 32'd0);
    chk("rst errs", {29'd0, err_misalign, err_range, err_overflow}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Three-word program load
    @(negedge clk); load_start = 1;
    @(negedge clk); load_start = 0;
    chk("load busy", {31'd0, busy}, 32'd1);
    chk("load rdy", {31'd0, load_rdy}, 32'd1);
    load_val = 1; load_data = 32'h0000_0013;
    @(negedge clk); load_data = 32'h0000_0011;
    @(negedge clk); load_data = 32'h0000_0022; load_last = 1;
    @(negedge clk); load_val = 0; load_last = 0;
    chk("load done pulse", {31'd0, load_done}, 32'd1);
    chk("load busy fall", {31'd0, busy}, 32'd0);
    chk("load rdy fall", {31'd0, load_rdy}, 32'd0);
    @(negedge clk);
    chk("load done once", {31'd0, load_done}, 32'd0);
    imemreq_val = 1; imemreq_addr = 32'h0; #1;
    chk("fetch 0x0", imemresp_data, 32'h0000_0013);
    @(negedge clk); imemreq_addr = 32'h4; #1;
    chk("fetch 0x4", imemresp_data, 32'h0000_0011);
    @(negedge clk); imemreq_addr = 32'h8; #1;
    chk("fetch 0x8", imemresp_data, 32'h0000_0022);
    @(negedge clk); imemreq_val = 0;
    chk("imem_cnt 3", imem_cnt, 32'd3);

    // Write then read-during-write at 0x10
    dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h10; dmemreq_wdata = 32'h1234_5678;
    @(negedge clk); dmemreq_wdata = 32'hDEAD_BEEF; #1;
    chk("rdw old", dmemresp_rdata, 32'h1234_5678);
    @(negedge clk); dmemreq_val = 0; dmemreq_type = 0; #1;
    chk("rdw new", dmemresp_rdata, 32'hDEAD_BEEF);
    chk("dmem_wr_cnt 2", dmem_wr_cnt, 32'd2);
    chk("dmem_rd_cnt 0", dmem_rd_cnt, 32'd0);

    // Out-of-range read, then clear
    @(negedge clk); dmemreq_val = 1; dmemreq_addr = 32'h400; #1;
    chk("oor data", dmemresp_rdata, 32'd0);
    @(negedge clk); dmemreq_val = 0;
    chk("oor flag", {31'd0, err_range}, 32'd1);
    chk("oor rd_cnt", dmem_rd_cnt, 32'd1);
    err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("oor clr", {31'd0, err_range}, 32'd0);

    // Clear coinciding with a new range event leaves the flag set
    err_clr = 1; imemreq_val = 1; imemreq_addr = 32'h400; #1;
    chk("oor fetch data", imemresp_data, 32'd0);
    @(negedge clk); imemreq_val = 0;
    chk("set wins", {31'd0, err_range}, 32'd1);
    @(negedge clk); err_clr = 0;
    chk("set wins clr", {31'd0, err_range}, 32'd0);

    // Misaligned fetch
    imemreq_val = 1; imemreq_addr = 32'h6; #1;
    chk("misalign data", imemresp_data, 32'h0000_0011);
    @(negedge clk); imemreq_val = 0;
    chk("misalign flag", {31'd0, err_misalign}, 32'd1);
    chk("misalign no range", {31'd0, err_range}, 32'd0);
    chk("imem_cnt 5", imem_cnt, 32'd5);
    err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("misalign clr", {31'd0, err_misalign}, 32'd0);

    // Overflow: 256 words, load_last never asserted
    load_start = 1;
    @(negedge clk); load_start = 0;
    for (int i = 0; i < 256; i++) begin
      load_val = 1; load_data = 32'hA000_0000 + i;
      imemreq_val = (i == 0); imemreq_addr = 32'h6;
      dmemreq_val = (i == 255); dmemreq_type = 1;
      dmemreq_addr = 32'h0; dmemreq_wdata = 32'hCCCC_CCCC;
      if (i == 0) begin
        #1;
        chk("load imem zero", imemresp_data, 32'd0);
      end
      if (i == 128) chk("ovf busy mid", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    dmemreq_val = 0; dmemreq_type = 0; imemreq_val = 0;
    load_data = 32'hBBBB_BBBB;
    chk("ovf flag", {31'd0, err_overflow}, 32'd1);
    chk("ovf busy", {31'd0, busy}, 32'd0);
    chk("ovf done", {31'd0, load_done}, 32'd1);
    chk("ovf no load errs", {30'd0, err_misalign, err_range}, 32'd0);
    chk("ovf imem_cnt hold", imem_cnt, 32'd5);
    chk("ovf wr_cnt hold", dmem_wr_cnt, 32'd2);
    @(negedge clk); load_val = 0;
    chk("ovf done once", {31'd0, load_done}, 32'd0);
    dmemreq_addr = 32'h3FC; #1;
    chk("ovf word255", dmemresp_rdata, 32'hA000_00FF);
    dmemreq_addr = 32'h0; #1;
    chk("ovf word0", dmemresp_rdata, 32'hA000_0000);

    // Reset in the middle of a load
    @(negedge clk); load_start = 1;
    @(negedge clk); load_start = 0;
    chk("start clears ovf", {31'd0, err_overflow}, 32'd0);
    load_val = 1; load_data = 32'h0000_0055;
    @(negedge clk); load_data = 32'h0000_0066;
    @(negedge clk); load_data = 32'h0000_0077;
    rst = 1'b0; #1;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst rdy", {31'd0, load_rdy}, 32'd0);
    chk("mid rst imem_cnt", imem_cnt, 32'd0);
    chk("mid rst rd_cnt", dmem_rd_cnt, 32'd0);
    chk("mid rst wr_cnt", dmem_wr_cnt, 32'd0);
    chk("mid rst done", {31'd0, load_done}, 32'd0);
    @(negedge clk);
    chk("mid rst done 2", {31'd0, load_done}, 32'd0);
    rst = 1'b1; load_val = 0;
    @(negedge clk);
    chk("mid rst done 3", {31'd0, load_done}, 32'd0);
    chk("mid rst serve", {31'd0, busy}, 32'd0);
    dmemreq_addr = 32'h0; #1;
    chk("kept word0", dmemresp_rdata, 32'h0000_0055);
    dmemreq_addr = 32'h4; #1;
    chk("kept word1", dmemresp_rdata, 32'h0000_0066);
    dmemreq_addr = 32'h8; #1;
    chk("word2 untouched", dmemresp_rdata, 32'hA000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
